mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high (`ResetEnable).
REQ-003 stall  input  `PipelineDepth  pipeline stall vector; bit 4 = mem_wb hold.
REQ-004 mem_rd_data  input  `RegLen  ALU result, or store data for stores.
REQ-005 mem_rd_addr  input  `RegAddrLen  destination register.
REQ-006 mem_mem_addr  input  `AddrLen  byte address of access.
REQ-007 mem_rd_enable  input  1  register write enable.
REQ-008 mem_width  input  4  [3]=store, [2]=unsigned load, [1:0] size: 00 none, 01 byte, 10 half, 11 word.
REQ-009 wb_rd_data / wb_rd_addr / wb_rd_enable  output  `RegLen / `RegAddrLen / 1  result to mem_wb.
REQ-010 stallreq_mem  output  1  pipeline stall request.
REQ-011 ram_req  output  1  byte access request; ram_we  output  1  1=write.
REQ-012 ram_addr  output  `AddrLen; ram_wdata  output  8; ram_rdata  input  8; ram_ready  input  1 (byte done, ram_rdata valid same cycle).

Function
REQ-013 States SHALL be IDLE, ACCESS, DONE; byte counter cnt 2 bits; load accumulator 32 bits.
REQ-014 Size 00 (incl. width 4'b0000) SHALL be a no-op: wb_* = mem_rd_* combinationally, stallreq_mem=0, zero latency, state stays IDLE.
REQ-015 IDLE with size!=00: stallreq_mem=1, wb_rd_enable=0, cnt<=0, next ACCESS.
REQ-016 ACCESS: ram_req=1, ram_we=mem_width[3], ram_addr=mem_mem_addr+cnt, ram_wdata=mem_rd_data[8*cnt+7:8*cnt]; stallreq_mem=1; wb_rd_enable=0.
REQ-017 ram_addr/ram_we/ram_wdata SHALL be stable while ram_req=1 and ram_ready=0.
REQ-018 On ram_ready in ACCESS: load stores ram_rdata into accumulator byte cnt; if cnt==nbytes-1 next DONE else cnt<=cnt+1 (ram_req stays high).
REQ-019 nbytes: byte=1, half=2, word=4; little-endian, byte k at address+k.
REQ-020 DONE: ram_req=0, stallreq_mem=0; wb_rd_addr=mem_rd_addr; wb_rd_enable=mem_rd_enable for loads, 0 for stores.
REQ-021 DONE load data: byte/half sign-extended when mem_width[2]=0, zero-extended when 1; word unchanged.
REQ-022 DONE SHALL persist while stall[4]==`StallEnable; otherwise next IDLE.
REQ-023 Latency: op accepted cycle 0; with ram_ready every ACCESS cycle, DONE at cycle nbytes+1.
REQ-024 No address alignment check; misaligned accesses proceed byte-wise, wrap at 2^32.

Reset
REQ-025 rst SHALL force IDLE, cnt=0, accumulator=0, ram_req=0 from the next cycle, including mid-ACCESS (partial data dropped, partial store not undone).
REQ-026 While rst asserted, outputs SHALL be zero: wb_*=0, stallreq_mem=0, ram_we=0, ram_addr=0, ram_wdata=0.

Structure
REQ-027 Width field encodings and state encodings SHALL reside in the shared defines header with `RegLen/`AddrLen/`PipelineDepth.
REQ-028 Single module; no sub-module.

Verification
REQ-029 width=0, mem_rd_data=32'h1234 -> same-cycle wb_rd_data=32'h1234, stallreq_mem=0, ram_req never 1.
REQ-030 Load word addr 0x100, ram_rdata 11,22,33,44, ready each cycle -> addrs 0x100..0x103, DONE cycle 5, wb_rd_data=32'h44332211.
REQ-031 Load byte signed, ram_rdata 8'h80 -> wb_rd_data=32'hFFFFFF80; unsigned -> 32'h00000080.
REQ-032 Store half addr 0x200, mem_rd_data=32'hAABBCCDD, ready delayed 2 cycles per byte -> writes DD@0x200, CC@0x201, ram signals stable during waits, wb_rd_enable=0.
REQ-033 rst pulse during byte 2 of load word -> next cycle IDLE, ram_req=0; re-issued load completes correctly.
REQ-034 stall[4]=1 for 3 cycles in DONE -> DONE held, no new ram_req; then IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, width-field and state encodings for mem_stage
package mem_stage_pkg;

  localparam int REG_LEN        = 32;
  localparam int REG_ADDR_LEN   = 5;
  localparam int ADDR_LEN       = 32;
  localparam int PIPELINE_DEPTH = 6;

  // stall vector bit that holds the mem_wb latch, and its asserted level
  localparam int   STALL_MEM_WB_BIT = 4;
  localparam logic STALL_ENABLE     = 1'b1;

  // mem_width field layout: [3]=store, [2]=unsigned load, [1:0]=access size
  localparam int WIDTH_STORE_BIT    = 3;
  localparam int WIDTH_UNSIGNED_BIT = 2;

  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // index of the final byte of an access of the given size
  function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
    case (size)
      SIZE_HALF: return 2'd1;
      SIZE_WORD: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  // sign- or zero-extend the assembled load bytes to register width
  function automatic logic [REG_LEN-1:0] load_extend(input logic [REG_LEN-1:0] raw,
                                                     input logic [1:0]         size,
                                                     input logic               uns);
    case (size)
      SIZE_BYTE: return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SIZE_HALF: return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default:   return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage issuing byte-serial loads and stores
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PIPELINE_DEPTH-1:0] stall,
  input  logic [REG_LEN-1:0]        mem_rd_data,
  input  logic [REG_ADDR_LEN-1:0]   mem_rd_addr,
  input  logic [ADDR_LEN-1:0]       mem_mem_addr,
  input  logic                      mem_rd_enable,
  input  logic [3:0]                mem_width,
  output logic [REG_LEN-1:0]        wb_rd_data,
  output logic [REG_ADDR_LEN-1:0]   wb_rd_addr,
  output logic                      wb_rd_enable,
  output logic                      stallreq_mem,
  output logic                      ram_req,
  output logic                      ram_we,
  output logic [ADDR_LEN-1:0]       ram_addr,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata,
  input  logic                      ram_ready
);

  state_t             state;
  logic [1:0]         cnt;
  logic [REG_LEN-1:0] acc;

  logic [1:0] size;
  logic       is_store;
  logic       is_unsigned;
  logic       has_access;
  logic       unused_stall;

  assign size        = mem_width[1:0];
  assign is_store    = mem_width[WIDTH_STORE_BIT];
  assign is_unsigned = mem_width[WIDTH_UNSIGNED_BIT];
  assign has_access  = (size != SIZE_NONE);

  // only the mem_wb hold bit matters here
  assign unused_stall = ^stall;

  // sequence IDLE -> ACCESS (one byte per ram_ready) -> DONE, holding DONE while mem_wb is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (has_access) begin
            cnt   <= 2'd0;
            acc   <= '0;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (ram_ready) begin
            if (!is_store) begin
              acc[{cnt, 3'b000} +: 8] <= ram_rdata;
            end
            if (cnt == last_byte_idx(size)) begin
              state <= ST_DONE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        ST_DONE: begin
          if (stall[STALL_MEM_WB_BIT] != STALL_ENABLE) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // outputs decode from the registered state; the ram port is a pure function of state/cnt
  // so it cannot move while a byte is waiting on ram_ready
  always_comb begin
    wb_rd_data   = '0;
    wb_rd_addr   = '0;
    wb_rd_enable = 1'b0;
    stallreq_mem = 1'b0;
    ram_req      = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = 8'd0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (has_access) begin
            stallreq_mem = 1'b1;
          end else begin
            wb_rd_data   = mem_rd_data;
            wb_rd_addr   = mem_rd_addr;
            wb_rd_enable = mem_rd_enable;
          end
        end
        ST_ACCESS: begin
          stallreq_mem = 1'b1;
          ram_req      = 1'b1;
          ram_we       = is_store;
          ram_addr     = mem_mem_addr + ADDR_LEN'(cnt);
          ram_wdata    = mem_rd_data[{cnt, 3'b000} +: 8];
        end
        ST_DONE: begin
          wb_rd_addr   = mem_rd_addr;
          wb_rd_enable = is_store ? 1'b0 : mem_rd_enable;
          wb_rd_data   = is_store ? '0 : load_extend(acc, size, is_unsigned);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a byte-memory model
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [31:0] mem_rd_data;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_mem_addr;
  logic        mem_rd_enable;
  logic [3:0]  mem_width;
  logic [31:0] wb_rd_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_enable;
  logic        stallreq_mem;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_mem_addr(mem_mem_addr),
    .mem_rd_enable(mem_rd_enable), .mem_width(mem_width),
    .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
    .stallreq_mem(stallreq_mem), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : (size == 2'd3) ? 4 : 0;
  endfunction

  // little-endian value of nb bytes at addr, then extended as a signed or unsigned quantity
  function automatic logic [31:0] exp_load(input logic [31:0] addr, input int nb, input logic uns);
    longint v = 0;
    for (int k = 0; k < nb; k++) v += longint'(mem_rd(addr + 32'(k))) << (8 * k);
    if (!uns && nb < 4 && v >= (64'sd1 <<< (8 * nb - 1))) v -= (64'sd1 <<< (8 * nb));
    return v[31:0];
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_wb_data"}, wb_rd_data, 32'd0);
    check({tag, "_wb_en"}, {31'd0, wb_rd_enable}, 32'd0);
    check({tag, "_stallreq"}, {31'd0, stallreq_mem}, 32'd0);
    check({tag, "_ram_req"}, {31'd0, ram_req}, 32'd0);
    check({tag, "_ram_addr"}, ram_addr, 32'd0);
  endtask

  // one instruction through the stage; byte waits drawn from [wmin,wmax], hold = DONE stall cycles
  task automatic run_op(input logic [3:0] width, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic en, input int wmin, input int wmax,
                        input int hold);
    int nb, k, wait_left, cyc;
    logic [31:0] exp_val;
    @(posedge clk); #1;
    mem_width = width; mem_mem_addr = addr; mem_rd_data = data;
    mem_rd_addr = rd; mem_rd_enable = en; stall = 6'd0; ram_ready = 1'b0;
    nb = nbytes(width[1:0]);
    #1;
    if (nb == 0) begin
      check("noop_data", wb_rd_data, data);
      check("noop_addr", {27'd0, wb_rd_addr}, {27'd0, rd});
      check("noop_en", {31'd0, wb_rd_enable}, {31'd0, en});
      check("noop_stallreq", {31'd0, stallreq_mem}, 32'd0);
      check("noop_ram_req", {31'd0, ram_req}, 32'd0);
      return;
    end
    exp_val = width[3] ? 32'd0 : exp_load(addr, nb, width[2]);
    check("accept_stallreq", {31'd0, stallreq_mem}, 32'd1);
    check("accept_wb_en", {31'd0, wb_rd_enable}, 32'd0);
    check("accept_ram_req", {31'd0, ram_req}, 32'd0);
    k = 0; cyc = 0;
    wait_left = int'($urandom_range(wmax, wmin));
    while (k < nb) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) begin
        check("access_timeout", 32'd0, 32'd1);
        return;
      end
      check("acc_ram_req", {31'd0, ram_req}, 32'd1);
      check("acc_stallreq", {31'd0, stallreq_mem}, 32'd1);
      check("acc_wb_en", {31'd0, wb_rd_enable}, 32'd0);
      check("acc_ram_addr", ram_addr, addr + 32'(k));
      check("acc_ram_we", {31'd0, ram_we}, {31'd0, width[3]});
      if (width[3]) check("acc_ram_wdata", {24'd0, ram_wdata}, {24'd0, 8'(data >> (8 * k))});
      if (wait_left == 0) begin
        ram_ready = 1'b1;
        if (width[3]) begin
          mem[addr + 32'(k)] = 8'(data >> (8 * k));
          ram_rdata = 8'($urandom);
        end else begin
          ram_rdata = mem_rd(addr + 32'(k));
        end
        k++;
        wait_left = int'($urandom_range(wmax, wmin));
      end else begin
        ram_ready = 1'b0;
        ram_rdata = 8'($urandom);
        wait_left--;
      end
    end
    @(posedge clk); #1;
    cyc++;
    ram_ready = 1'b0;
    if (wmax == 0) check("done_latency", 32'(cyc), 32'(nb + 1));
    for (int h = 0; h <= hold; h++) begin
      stall = (h < hold) ? 6'b010000 : 6'd0;
      check("done_stallreq", {31'd0, stallreq_mem}, 32'd0);
      check("done_ram_req", {31'd0, ram_req}, 32'd0);
      check("done_wb_addr", {27'd0, wb_rd_addr}, {27'd0, rd});
      check("done_wb_en", {31'd0, wb_rd_enable}, {31'd0, en & ~width[3]});
      if (!width[3]) check("done_wb_data", wb_rd_data, exp_val);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [3:0]  w;
    logic [31:0] a;
    rst = 1'b1; stall = 6'd0; ram_ready = 1'b0; ram_rdata = 8'd0;
    mem_width = 4'b0011; mem_mem_addr = 32'h55; mem_rd_data = 32'hDEADBEEF;
    mem_rd_addr = 5'd7; mem_rd_enable = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("reset");
    @(posedge clk); #1;
    check_idle_zero("reset2");
    mem_width = 4'b0000;
    rst = 1'b0;

    // pass-through no-op
    run_op(4'b0000, 32'h0, 32'h1234, 5'd3, 1'b1, 0, 0, 0);

    // load word with back-to-back ready
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    run_op(4'b0011, 32'h100, 32'h0, 5'd9, 1'b1, 0, 0, 0);
    check("word_expect_const", exp_load(32'h100, 4, 1'b0), 32'h44332211);

    // signed and unsigned byte of 0x80
    mem[32'h300] = 8'h80;
    run_op(4'b0001, 32'h300, 32'h0, 5'd4, 1'b1, 0, 0, 0);
    run_op(4'b0101, 32'h300, 32'h0, 5'd4, 1'b1, 0, 0, 0);

    // store half with two wait cycles per byte
    mem[32'h202] = 8'h5A;
    run_op(4'b1010, 32'h200, 32'hAABBCCDD, 5'd6, 1'b1, 2, 2, 0);
    check("store_byte0", {24'd0, mem[32'h200]}, 32'hDD);
    check("store_byte1", {24'd0, mem[32'h201]}, 32'hCC);
    check("store_byte2_untouched", {24'd0, mem[32'h202]}, 32'h5A);

    // DONE held by mem_wb stall for 3 cycles
    run_op(4'b0010, 32'h400, 32'h0, 5'd12, 1'b1, 0, 1, 3);

    // reset while the second byte of a word load is outstanding
    @(posedge clk); #1;
    mem_width = 4'b0011; mem_mem_addr = 32'h500; mem_rd_addr = 5'd2; mem_rd_enable = 1'b1;
    ram_ready = 1'b0;
    @(posedge clk); #1;
    ram_ready = 1'b1; ram_rdata = mem_rd(32'h500);
    @(posedge clk); #1;
    check("rst_pre_addr", ram_addr, 32'h501);
    ram_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_width = 4'b0000;
    #1;
    check("rst_after_ram_req", {31'd0, ram_req}, 32'd0);
    check("rst_after_stallreq", {31'd0, stallreq_mem}, 32'd0);
    run_op(4'b0011, 32'h500, 32'h0, 5'd2, 1'b1, 0, 1, 0);

    // wrap past the top of the address space
    run_op(4'b0011, 32'hFFFF_FFFE, 32'h0, 5'd1, 1'b1, 0, 0, 0);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      w = 4'($urandom);
      a = (i % 10 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(2, 0)) : 32'h1000 + 32'($urandom_range(63, 0));
      run_op(w, a, $urandom, 5'($urandom), 1'($urandom), 0, 3, int'($urandom_range(2, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
